// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DWAIT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare: a load in EX whose destination is read by the ID instruction.
module pipe_hazard_ctrl_hazard_detect #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_dst,
  output logic             lu
);

  logic w_rs_hit, w_rt_hit;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign w_rs_hit = id_uses_rs & (id_rs == ex_dst);
  assign w_rt_hit = id_uses_rt & (id_rt == ex_dst);
  assign lu       = ex_memread & (ex_dst != '0) & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: drives pipeline register enables, IF/ID flush,
// ID/EX bubble select, halt status and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_br_taken,
  input  logic             id_hlt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             wb_hlt,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_wren,
  output logic             ifid_wren,
  output logic             ifid_flush,
  output logic             idex_wren,
  output logic             idex_bubble,
  output logic             exmem_wren,
  output logic             memwb_wren,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  hz_state_t        r_state, w_nxt;
  logic             r_ret_drain, w_ret_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lu, w_mode_drain;
  logic             w_pc, w_ifid, w_flush, w_idex, w_bub, w_exm, w_mwb, w_halted;

  pipe_hazard_ctrl_hazard_detect #(.REG_W(REG_W)) u_hd (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_dst     (ex_dst),
    .lu         (w_lu)
  );

  // DWAIT resolves with the rules of the state it froze out of.
  assign w_mode_drain = (r_state == ST_DRAIN) || ((r_state == ST_DWAIT) && r_ret_drain);

  // Priority encoder: dcache freeze > load-use > drain/halt > branch > icache miss.
  always_comb begin
    w_pc = 1'b0; w_ifid = 1'b0; w_flush = 1'b0; w_idex = 1'b0;
    w_bub = 1'b0; w_exm = 1'b0; w_mwb = 1'b0; w_halted = 1'b0;
    w_nxt = r_state;
    w_ret_nxt = r_ret_drain;
    if (r_state == ST_HALTED) begin
      w_halted = 1'b1;
    end else if (dmem_busy) begin
      w_nxt = ST_DWAIT;
      if (r_state != ST_DWAIT) w_ret_nxt = (r_state == ST_DRAIN);
    end else if (w_lu) begin
      // Hold PC and IF/ID; one bubble into EX while the load moves on.
      w_idex = 1'b1; w_bub = 1'b1; w_exm = 1'b1; w_mwb = 1'b1;
      w_nxt = w_mode_drain ? (wb_hlt ? ST_HALTED : ST_DRAIN) : ST_RUN;
    end else if (w_mode_drain) begin
      // Everything behind HLT is squashed; branch and icache are ignored.
      w_ifid = 1'b1; w_flush = 1'b1; w_idex = 1'b1; w_bub = 1'b1;
      w_exm = 1'b1; w_mwb = 1'b1;
      w_nxt = wb_hlt ? ST_HALTED : ST_DRAIN;
    end else if (id_hlt) begin
      // HLT itself advances into ID/EX; fetch stops behind it.
      w_ifid = 1'b1; w_flush = 1'b1; w_idex = 1'b1; w_exm = 1'b1; w_mwb = 1'b1;
      w_nxt = ST_DRAIN;
    end else if (id_br_taken) begin
      w_pc = 1'b1; w_ifid = 1'b1; w_flush = 1'b1; w_idex = 1'b1;
      w_exm = 1'b1; w_mwb = 1'b1;
      w_nxt = ST_RUN;
    end else if (imem_busy) begin
      w_ifid = 1'b1; w_flush = 1'b1; w_idex = 1'b1; w_exm = 1'b1; w_mwb = 1'b1;
      w_nxt = ST_RUN;
    end else begin
      w_pc = 1'b1; w_ifid = 1'b1; w_idex = 1'b1; w_exm = 1'b1; w_mwb = 1'b1;
      w_nxt = ST_RUN;
    end
  end

  // Reset forces every control output low without waiting for a clock.
  assign pc_wren     = rst & w_pc;
  assign ifid_wren   = rst & w_ifid;
  assign ifid_flush  = rst & w_flush;
  assign idex_wren   = rst & w_idex;
  assign idex_bubble = rst & w_bub;
  assign exmem_wren  = rst & w_exm;
  assign memwb_wren  = rst & w_mwb;
  assign halted      = rst & w_halted;
  assign stall_cnt   = r_stall_cnt;

  // State, return flag and saturating stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_ret_drain <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_nxt;
      r_ret_drain <= w_ret_nxt;
      if (!w_pc && (r_state != ST_HALTED) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  // Output vector order: {pc, ifid, flush, idex, bubble, exmem, memwb, halted}
  localparam logic [7:0] ALL   = 8'b1101_0110;
  localparam logic [7:0] ZERO  = 8'b0000_0000;
  localparam logic [7:0] LU    = 8'b0001_1110;
  localparam logic [7:0] BR    = 8'b1111_0110;
  localparam logic [7:0] IMEM  = 8'b0111_0110;
  localparam logic [7:0] HENT  = 8'b0111_0110;
  localparam logic [7:0] DRAIN = 8'b0111_1110;
  localparam logic [7:0] HALT  = 8'b0000_0001;

  typedef struct packed {
    logic [7:0]  o;
    logic [15:0] c;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] id_rs = '0, id_rt = '0, ex_dst = '0;
  logic id_uses_rs = 0, id_uses_rt = 0, id_br_taken = 0, id_hlt = 0;
  logic ex_memread = 0, wb_hlt = 0, imem_busy = 0, dmem_busy = 0;
  logic pc_wren, ifid_wren, ifid_flush, idex_wren, idex_bubble;
  logic exmem_wren, memwb_wren, halted;
  logic [15:0] stall_cnt;

  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [15:0] exp_cnt = '0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_br_taken(id_br_taken), .id_hlt(id_hlt), .ex_memread(ex_memread),
    .ex_dst(ex_dst), .wb_hlt(wb_hlt), .imem_busy(imem_busy),
    .dmem_busy(dmem_busy), .pc_wren(pc_wren), .ifid_wren(ifid_wren),
    .ifid_flush(ifid_flush), .idex_wren(idex_wren), .idex_bubble(idex_bubble),
    .exmem_wren(exmem_wren), .memwb_wren(memwb_wren), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Push expectation, let outputs settle, pop and compare.
  task automatic cmp(input string tag, input logic [7:0] eo);
    exp_t e, got;
    sb.push_back('{o: eo, c: exp_cnt});
    #1;
    got = '{o: {pc_wren, ifid_wren, ifid_flush, idex_wren, idex_bubble,
                exmem_wren, memwb_wren, halted}, c: stall_cnt};
    e = sb.pop_front();
    checks++;
    assert (got.o === e.o) else begin
      errors++;
      $error("FAIL %s outputs: got %b want %b", tag, got.o, e.o);
    end
    checks++;
    assert (got.c === e.c) else begin
      errors++;
      $error("FAIL %s stall_cnt: got %0d want %0d", tag, got.c, e.c);
    end
  endtask

  // One clocked step: compare, advance the counter model, move to next negedge.
  task automatic step(input string tag, input logic [7:0] eo);
    cmp(tag, eo);
    if (rst && !eo[7] && !eo[0] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_dst = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_br_taken = 0; id_hlt = 0; ex_memread = 0; wb_hlt = 0;
    imem_busy = 0; dmem_busy = 0;
  endtask

  task automatic set_lu_rs(input logic [3:0] r);
    ex_memread = 1; ex_dst = r; id_rs = r; id_uses_rs = 1;
  endtask

  initial begin
    #2 cmp("reset", ZERO);
    @(negedge clk);
    rst = 1; idle();
    step("idle", ALL);

    set_lu_rs(4'd3);          step("lu_rs", LU);
    ex_memread = 0;           step("lu_clear", ALL);
    set_lu_rs(4'd0);          step("r0_load", ALL);
    idle(); ex_memread = 1; ex_dst = 5; id_rt = 5; id_uses_rt = 1;
                              step("lu_rt", LU);
    id_uses_rt = 0;           step("rt_unused", ALL);
    idle(); id_br_taken = 1; imem_busy = 1;
                              step("br_imem", BR);
    id_br_taken = 0;          step("imem_only", IMEM);
    idle(); id_br_taken = 1; set_lu_rs(4'd7);
                              step("br_lu_defer", LU);
    ex_memread = 0;           step("br_after_lu", BR);

    idle(); set_lu_rs(4'd2); dmem_busy = 1;
    for (int i = 0; i < 4; i++) step("dfreeze", ZERO);
    dmem_busy = 0;            step("dfreeze_lu", LU);
    ex_memread = 0;           step("dfreeze_done", ALL);

    idle(); id_hlt = 1;       step("hlt_entry", HENT);
    id_hlt = 0;               step("drain1", DRAIN);
    id_br_taken = 1; imem_busy = 1;
                              step("drain_ignore", DRAIN);
    idle(); dmem_busy = 1;    step("drain_dwait", ZERO);
    dmem_busy = 0;            step("drain_ret", DRAIN);
    wb_hlt = 1;               step("drain_wb", DRAIN);
    wb_hlt = 0;               step("halted1", HALT);
    id_br_taken = 1;          step("halted2", HALT);
    idle();
    #2 rst = 0; exp_cnt = '0;
    cmp("halt_reset", ZERO);
    @(negedge clk);
    rst = 1;                  step("after_reset", ALL);

    dmem_busy = 1;            step("dwait_a", ZERO);
    step("dwait_b", ZERO);
    #2 rst = 0; exp_cnt = '0;
    cmp("async_rst", ZERO);
    @(negedge clk);
    idle(); rst = 1;          step("post_async", ALL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the write enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, plus the IF/ID flush and the ID/EX bubble select.
- Arbitrates between data-cache miss freeze, load-use stall, taken-branch flush, instruction-cache miss bubbles and HLT drain.
- Sits beside the pipeline registers at the top of the CPU. One FSM plus a stall-cycle counter.

Parameters:
- REG_W, 4, register-specifier width
- CNT_W, 16, stall-cycle counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs  in  REG_W  source register 1 of the instruction in ID
- id_rt  in  REG_W  source register 2 of the instruction in ID
- id_uses_rs  in  1  ID instruction reads id_rs
- id_uses_rt  in  1  ID instruction reads id_rt
- id_br_taken  in  1  ID resolved a taken branch this cycle
- id_hlt  in  1  ID holds HLT
- ex_memread  in  1  EX holds a load (ID/EX MemRead output)
- ex_dst  in  REG_W  EX destination register (ID/EX dst_reg output)
- wb_hlt  in  1  HLT has reached WB
- imem_busy  in  1  instruction fetch not ready (level)
- dmem_busy  in  1  data access not ready (level)
- pc_wren  out  1  PC update enable
- ifid_wren  out  1  IF/ID write enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_wren  out  1  ID/EX write enable
- idex_bubble  out  1  zero all ID/EX control inputs this write
- exmem_wren  out  1  EX/MEM write enable
- memwb_wren  out  1  MEM/WB write enable
- halted  out  1  processor halted
- stall_cnt  out  CNT_W  cycles with pc_wren=0 while not halted

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, stall_cnt=0. While rst=0, all wren, flush, bubble and halted outputs are 0.
- FSM states: RUN, DWAIT, DRAIN, HALTED. Outputs are combinational from state and inputs; state and counter are registered.
- Load-use hazard: lu = ex_memread & (ex_dst!=0) & ((id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)). Register 0 never causes a hazard.
- Priority within RUN/DRAIN, highest first:
  1. dmem_busy: all five wren=0, no flush, no bubble. The state goes to DWAIT next cycle while busy persists.
  2. lu: pc_wren=0, ifid_wren=0, idex_bubble=1. ID/EX, EX/MEM and MEM/WB wren=1. Exactly one bubble per load-use (lu drops once the load leaves EX).
  3. id_br_taken: all wren=1, ifid_flush=1.
  4. imem_busy: pc_wren=0, ifid_wren=1 with ifid_flush=1. The rest advance.
  5. Otherwise all wren=1.
- DWAIT: all wren=0 while dmem_busy=1. On the first cycle with dmem_busy=0, apply RUN rules combinationally and return to the pre-freeze state (RUN or DRAIN). A one-bit return flag holds that state.
- HLT entry: in RUN with id_hlt=1 and no lu or dmem_busy, go to DRAIN.
- DRAIN:
  - pc_wren=0 and ifid_flush=1 every advancing cycle.
  - ID/EX advances carrying HLT; subsequent ID/EX writes are bubbles (idex_bubble=1).
  - id_br_taken and imem_busy are ignored.
- DRAIN to HALTED: when wb_hlt=1.
- HALTED: all wren=0, halted=1. Terminal until reset.
- Simultaneous events: dmem_busy masks lu, branch and halt for that cycle. A branch with lu is deferred until the stall clears (the ID instruction is re-evaluated).
- stall_cnt: increments on every cycle with pc_wren=0 and state!=HALTED; saturates at all-ones. Reset mid-operation clears it.

Decomposition:
- Shared package: FSM state encoding (2 bits: RUN=0, DWAIT=1, DRAIN=2, HALTED=3) and the REG_W/CNT_W defaults.
- One natural sub-module: hazard_detect (combinational lu compare).
- FSM, priority encoder and counter stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_memread=1, ex_dst=3, id_rs=3, id_uses_rs=1 → one cycle with pc_wren=0, ifid_wren=0, idex_bubble=1, stall_cnt=1. Next cycle with ex_memread=0 → all wren=1.
- R0 load: ex_dst=0, id_rs=0, ex_memread=1 → no stall, all wren=1.
- Branch with imem_busy: id_br_taken=1 and imem_busy=1 → ifid_flush=1, pc_wren=1 (branch wins).
- Dcache freeze: dmem_busy=1 for 4 cycles during a load-use → all wren=0 for those 4 cycles. Then a single lu bubble follows. stall_cnt=5.
- Halt: id_hlt=1 → DRAIN with pc_wren=0. Assert wb_hlt three cycles later → halted=1 and all wren=0 thereafter. Drop rst → halted=0, stall_cnt=0, state RUN.
- Async reset mid-DWAIT: assert rst=0 between clock edges → outputs clear immediately without waiting for clk.
